fetch_queue_unit: RTL and testbench

Parametrised successor to the dual-issue fetch stage. It fetches up to FETCH_WIDTH instructions per bus transaction into a circular instruction queue and presents up to ISSUE_WIDTH entries per cycle to decode. Redirects flush the queue and discard in-flight responses. It sits between the flex instruction bus and the decode stages, so the icache is decoupled from decode back-pressure.

---
 rtl/fetch_queue_unit_pkg.sv | 24 ++
 rtl/fetch_entry_queue.sv | 70 +++++++
 rtl/fetch_queue_unit.sv | 164 ++++++++++++++++
 tb/tb_fetch_queue_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_unit_pkg.sv
// Shared fetch types: FSM states, queue entry layout and the kseg address check
// (also used by the LSU).
package fetch_queue_unit_pkg;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_STALL = 2'd2,
    S_HALT  = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
    logic        irq;
  } fetch_entry_t;

  // Misaligned, or outside kseg0/kseg1 (0x8xxxxxxx..0xbxxxxxxx).
  function automatic logic kseg_addr_bad(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || (addr[31:28] < 4'h8) || (addr[31:28] > 4'hb);
  endfunction

endpackage

// File: rtl/fetch_entry_queue.sv
// Circular entry buffer: up to PUSH_W writes and up to POP_W reads per cycle.
// Occupancy is tracked with a count, so full and empty never alias.
module fetch_entry_queue
  import fetch_queue_unit_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned PUSH_W = 2,
  parameter int unsigned POP_W  = 2,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1),
  localparam int unsigned PW = $clog2(PUSH_W + 1)
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      i_flush,
  input  logic [PW-1:0]             i_push_n,
  input  fetch_entry_t [PUSH_W-1:0] i_push_data,
  input  logic                      i_pop,
  output logic [POP_W-1:0]          o_valid,
  output fetch_entry_t [POP_W-1:0]  o_data,
  output logic [CW-1:0]             o_free,
  output logic [CW-1:0]             o_pop_n
);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_pop_n;

  always_comb begin
    w_pop_n = '0;
    if (i_pop) w_pop_n = (r_count < CW'(POP_W)) ? r_count : CW'(POP_W);
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < PUSH_W; i++) begin
      if (resetn && !i_flush && (PW'(i) < i_push_n))
        r_mem[r_tail + AW'(i)] <= i_push_data[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn || i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_tail  <= r_tail + AW'(i_push_n);
      r_head  <= r_head + AW'(w_pop_n);
      r_count <= r_count + CW'(i_push_n) - w_pop_n;
    end
  end

  always_comb begin
    o_valid = '0;
    o_data  = '0;
    for (int unsigned k = 0; k < POP_W; k++) begin
      o_valid[k] = (CW'(k) < r_count);
      o_data[k]  = r_mem[r_head + AW'(k)];
    end
  end

  assign o_free  = CW'(DEPTH) - r_count;
  assign o_pop_n = w_pop_n;

  a_no_overflow: assert property (@(posedge clk)
    (resetn && !i_flush) |-> (CW'(i_push_n) <= o_free));

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch stage: issues one outstanding ibus request at a time into a circular
// instruction queue and presents up to ISSUE_WIDTH entries per cycle to decode.
module fetch_queue_unit
  import fetch_queue_unit_pkg::*;
#(
  parameter int unsigned FETCH_WIDTH = 2,
  parameter int unsigned ISSUE_WIDTH = 2,
  parameter int unsigned QUEUE_DEPTH = 8,
  parameter logic [31:0] RESET_PC    = 32'hbfc00000,
  localparam int unsigned CNT_W = $clog2(FETCH_WIDTH + 1)
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        redirect_valid,
  input  logic [31:0]                 redirect_pc,
  input  logic                        irq_pending,
  output logic                        ireq_valid,
  output logic [31:0]                 ireq_addr,
  input  logic                        iresp_addr_ok,
  input  logic                        iresp_data_ok,
  input  logic [CNT_W-1:0]            iresp_count,
  input  logic [32*FETCH_WIDTH-1:0]   iresp_data,
  output logic [ISSUE_WIDTH-1:0]      out_valid,
  output logic [32*ISSUE_WIDTH-1:0]   out_pc,
  output logic [32*ISSUE_WIDTH-1:0]   out_instr,
  output logic [ISSUE_WIDTH-1:0]      out_adel,
  output logic [ISSUE_WIDTH-1:0]      out_irq,
  input  logic                        deq_ready
);

  localparam int unsigned CW = $clog2(QUEUE_DEPTH + 1);

  fetch_state_t r_state, w_state_nxt;
  logic [31:0]  r_pc, w_pc_nxt;
  logic         r_discard, w_discard_nxt;

  logic [CNT_W-1:0]               w_push_n;
  fetch_entry_t [FETCH_WIDTH-1:0] w_push_data;
  fetch_entry_t [ISSUE_WIDTH-1:0] w_q_data;
  logic [ISSUE_WIDTH-1:0]         w_q_valid;
  logic [CW-1:0]                  w_free, w_pop_n, w_free_pop;
  logic w_addr_bad, w_req, w_acc, w_pop, w_stall_after_rsp;

  assign w_addr_bad = kseg_addr_bad(r_pc);
  assign w_req      = resetn && (r_state == S_FETCH) && !w_addr_bad;
  assign w_acc      = w_req && iresp_addr_ok;
  assign w_pop      = deq_ready && !redirect_valid;
  // Free slots after this cycle's pop; stall if a response push leaves < FETCH_WIDTH.
  assign w_free_pop        = w_free + w_pop_n;
  assign w_stall_after_rsp = (w_free_pop < CW'(FETCH_WIDTH) + CW'(iresp_count));

  always_comb begin
    w_push_data = '0;
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      w_push_data[i].pc    = r_pc + 32'(4 * i);
      w_push_data[i].instr = iresp_data[32*i +: 32];
      w_push_data[i].adel  = 1'b0;
      w_push_data[i].irq   = irq_pending;
    end
    if (w_addr_bad) begin
      w_push_data[0].instr = '0;
      w_push_data[0].adel  = 1'b1;
    end
  end

  fetch_entry_queue #(
    .DEPTH  (QUEUE_DEPTH),
    .PUSH_W (FETCH_WIDTH),
    .POP_W  (ISSUE_WIDTH)
  ) u_queue (
    .clk         (clk),
    .resetn      (resetn),
    .i_flush     (redirect_valid),
    .i_push_n    (w_push_n),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_valid     (w_q_valid),
    .o_data      (w_q_data),
    .o_free      (w_free),
    .o_pop_n     (w_pop_n)
  );

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_FETCH;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_pc      <= RESET_PC;
      r_discard <= 1'b0;
    end else begin
      r_pc      <= w_pc_nxt;
      r_discard <= w_discard_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_discard_nxt = r_discard;
    w_push_n      = '0;
    if (redirect_valid) begin
      // An accepted request whose data has not yet returned must be drained.
      w_pc_nxt      = redirect_pc;
      w_state_nxt   = S_FETCH;
      w_discard_nxt = 1'b0;
      if (((r_state == S_FETCH) && w_acc && !iresp_data_ok) ||
          ((r_state == S_WAIT) && !iresp_data_ok)) begin
        w_state_nxt   = S_WAIT;
        w_discard_nxt = 1'b1;
      end
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_addr_bad) begin
            w_push_n    = CNT_W'(1);
            w_state_nxt = S_HALT;
          end else if (w_acc && iresp_data_ok) begin
            w_push_n    = iresp_count;
            w_pc_nxt    = r_pc + (32'(iresp_count) << 2);
            w_state_nxt = w_stall_after_rsp ? S_STALL : S_FETCH;
          end else if (w_acc) begin
            w_state_nxt = S_WAIT;
          end
        end
        S_WAIT: begin
          if (iresp_data_ok) begin
            if (r_discard) begin
              w_discard_nxt = 1'b0;
              w_state_nxt   = S_FETCH;
            end else begin
              w_push_n    = iresp_count;
              w_pc_nxt    = r_pc + (32'(iresp_count) << 2);
              w_state_nxt = w_stall_after_rsp ? S_STALL : S_FETCH;
            end
          end
        end
        S_STALL: if (w_free_pop >= CW'(FETCH_WIDTH)) w_state_nxt = S_FETCH;
        S_HALT:  w_state_nxt = S_HALT;
      endcase
    end
  end

  always_comb begin
    ireq_valid = w_req;
    ireq_addr  = resetn ? r_pc : '0;
    out_valid  = '0;
    out_pc     = '0;
    out_instr  = '0;
    out_adel   = '0;
    out_irq    = '0;
    if (resetn) begin
      for (int unsigned k = 0; k < ISSUE_WIDTH; k++) begin
        out_valid[k]        = w_q_valid[k] && !redirect_valid;
        out_pc[32*k +: 32]    = w_q_data[k].pc;
        out_instr[32*k +: 32] = w_q_data[k].instr;
        out_adel[k]         = w_q_data[k].adel;
        out_irq[k]          = w_q_data[k].irq;
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit with FETCH_WIDTH=2, ISSUE_WIDTH=2, QUEUE_DEPTH=8.
module tb_fetch_queue_unit;

  logic        clk, resetn, redirect_valid, irq_pending, iresp_addr_ok, iresp_data_ok, deq_ready;
  logic [31:0] redirect_pc, ireq_addr;
  logic        ireq_valid;
  logic [1:0]  iresp_count;
  logic [63:0] iresp_data, out_pc, out_instr;
  logic [1:0]  out_valid, out_adel, out_irq;

  int n_cmp = 0;
  int n_fail = 0;

  fetch_queue_unit #(
    .FETCH_WIDTH (2),
    .ISSUE_WIDTH (2),
    .QUEUE_DEPTH (8),
    .RESET_PC    (32'hbfc00000)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .irq_pending    (irq_pending),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .iresp_addr_ok  (iresp_addr_ok),
    .iresp_data_ok  (iresp_data_ok),
    .iresp_count    (iresp_count),
    .iresp_data     (iresp_data),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_adel       (out_adel),
    .out_irq        (out_irq),
    .deq_ready      (deq_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resp(input logic [1:0] c, input logic [63:0] d);
    iresp_addr_ok = 1'b1; iresp_data_ok = 1'b1; iresp_count = c; iresp_data = d;
    tick();
    iresp_addr_ok = 1'b0; iresp_data_ok = 1'b0; iresp_count = 2'd0; iresp_data = '0;
    #1;
  endtask

  task automatic pop_all();
    deq_ready = 1'b1;
    tick();
    deq_ready = 1'b0;
    #1;
  endtask

  task automatic redir(input logic [31:0] pc);
    redirect_valid = 1'b1; redirect_pc = pc;
    tick();
    redirect_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) tick();
    n_cmp++; if (ireq_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req got=%b exp=0", ireq_valid); end
    n_cmp++; if (ireq_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr got=%h exp=0", ireq_addr); end
    n_cmp++; if (out_valid !== 2'b00) begin n_fail++; $display("FAIL rst_valid got=%b exp=00", out_valid); end
    resetn = 1'b1;
    #1;
    n_cmp++; if (ireq_valid !== 1'b1) begin n_fail++; $display("FAIL post_rst_req got=%b exp=1", ireq_valid); end
    n_cmp++; if (ireq_addr !== 32'hbfc00000) begin n_fail++; $display("FAIL post_rst_addr got=%h exp=bfc00000", ireq_addr); end
  endtask

  task automatic test_single();
    resp(2'd2, {32'hbbbb0002, 32'haaaa0001});
    n_cmp++; if (out_valid !== 2'b11) begin n_fail++; $display("FAIL single_valid got=%b exp=11", out_valid); end
    n_cmp++; if (out_pc !== {32'hbfc00004, 32'hbfc00000}) begin n_fail++; $display("FAIL single_pc got=%h exp=bfc00004bfc00000", out_pc); end
    n_cmp++; if (out_instr !== {32'hbbbb0002, 32'haaaa0001}) begin n_fail++; $display("FAIL single_instr got=%h", out_instr); end
    n_cmp++; if (ireq_addr !== 32'hbfc00008) begin n_fail++; $display("FAIL single_nextpc got=%h exp=bfc00008", ireq_addr); end
    pop_all();
    n_cmp++; if (out_valid !== 2'b00) begin n_fail++; $display("FAIL single_drained got=%b exp=00", out_valid); end
  endtask

  task automatic test_partial();
    resp(2'd1, {32'h0, 32'hcccc0003});
    n_cmp++; if (out_valid !== 2'b01) begin n_fail++; $display("FAIL part_valid got=%b exp=01", out_valid); end
    n_cmp++; if (out_pc[31:0] !== 32'hbfc00008) begin n_fail++; $display("FAIL part_pc got=%h exp=bfc00008", out_pc[31:0]); end
    n_cmp++; if (ireq_addr !== 32'hbfc0000c) begin n_fail++; $display("FAIL part_nextpc got=%h exp=bfc0000c", ireq_addr); end
    tick();
    n_cmp++; if (out_valid !== 2'b01) begin n_fail++; $display("FAIL part_hold got=%b exp=01", out_valid); end
    pop_all();
    // Two-cycle transaction through S_WAIT.
    iresp_addr_ok = 1'b1;
    tick();
    iresp_addr_ok = 1'b0;
    #1;
    n_cmp++; if (ireq_valid !== 1'b0) begin n_fail++; $display("FAIL wait_req got=%b exp=0", ireq_valid); end
    iresp_data_ok = 1'b1; iresp_count = 2'd2; iresp_data = {32'hdddd0005, 32'hdddd0004};
    tick();
    iresp_data_ok = 1'b0; iresp_count = 2'd0;
    #1;
    n_cmp++; if (out_pc !== {32'hbfc00010, 32'hbfc0000c}) begin n_fail++; $display("FAIL wait_pc got=%h exp=bfc00010bfc0000c", out_pc); end
    n_cmp++; if (ireq_addr !== 32'hbfc00014 || ireq_valid !== 1'b1) begin n_fail++; $display("FAIL wait_next got=%h/%b exp=bfc00014/1", ireq_addr, ireq_valid); end
    pop_all();
  endtask

  task automatic test_stall();
    logic [31:0] exp_pc;
    for (int i = 0; i < 3; i++) resp(2'd2, {32'h1000 + 32'(2*i+1), 32'h1000 + 32'(2*i)});
    n_cmp++; if (ireq_valid !== 1'b1) begin n_fail++; $display("FAIL stall_six_req got=%b exp=1", ireq_valid); end
    resp(2'd2, {32'h1007, 32'h1006});
    n_cmp++; if (ireq_valid !== 1'b0) begin n_fail++; $display("FAIL stall_full_req got=%b exp=0", ireq_valid); end
    n_cmp++; if (out_pc !== {32'hbfc00018, 32'hbfc00014}) begin n_fail++; $display("FAIL stall_head got=%h", out_pc); end
    tick();
    n_cmp++; if (ireq_valid !== 1'b0) begin n_fail++; $display("FAIL stall_hold_req got=%b exp=0", ireq_valid); end
    pop_all();
    n_cmp++; if (ireq_valid !== 1'b1 || ireq_addr !== 32'hbfc00034) begin n_fail++; $display("FAIL stall_resume got=%b/%h exp=1/bfc00034", ireq_valid, ireq_addr); end
    for (int k = 0; k < 3; k++) begin
      exp_pc = 32'hbfc0001c + 32'(8*k);
      n_cmp++; if (out_valid !== 2'b11 || out_pc[31:0] !== exp_pc) begin n_fail++; $display("FAIL stall_drain%0d got=%b/%h exp=11/%h", k, out_valid, out_pc[31:0], exp_pc); end
      pop_all();
    end
    n_cmp++; if (out_valid !== 2'b00) begin n_fail++; $display("FAIL stall_empty got=%b exp=00", out_valid); end
  endtask

  task automatic test_redirect_wait();
    resp(2'd2, {32'heeee0001, 32'heeee0000});
    iresp_addr_ok = 1'b1;
    tick();
    iresp_addr_ok = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h80001000;
    #1;
    n_cmp++; if (out_valid !== 2'b00) begin n_fail++; $display("FAIL redir_mask got=%b exp=00", out_valid); end
    tick();
    redirect_valid = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 2'b00 || ireq_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush got=%b/%b exp=00/0", out_valid, ireq_valid); end
    repeat (2) tick();
    n_cmp++; if (ireq_valid !== 1'b0) begin n_fail++; $display("FAIL redir_wait_req got=%b exp=0", ireq_valid); end
    iresp_data_ok = 1'b1; iresp_count = 2'd2; iresp_data = {32'hdead0001, 32'hdead0000};
    tick();
    iresp_data_ok = 1'b0; iresp_count = 2'd0;
    #1;
    n_cmp++; if (out_valid !== 2'b00) begin n_fail++; $display("FAIL redir_stale got=%b exp=00", out_valid); end
    n_cmp++; if (ireq_valid !== 1'b1 || ireq_addr !== 32'h80001000) begin n_fail++; $display("FAIL redir_target got=%b/%h exp=1/80001000", ireq_valid, ireq_addr); end
    resp(2'd2, {32'h12340001, 32'h12340000});
    n_cmp++; if (out_pc !== {32'h80001004, 32'h80001000} || out_instr[31:0] !== 32'h12340000) begin n_fail++; $display("FAIL redir_new got=%h/%h", out_pc, out_instr); end
    pop_all();
  endtask

  task automatic test_halt();
    redir(32'h00400000);
    n_cmp++; if (ireq_valid !== 1'b0) begin n_fail++; $display("FAIL halt_noreq got=%b exp=0", ireq_valid); end
    tick();
    n_cmp++; if (out_valid !== 2'b01 || out_adel !== 2'b01) begin n_fail++; $display("FAIL halt_entry got=%b/%b exp=01/01", out_valid, out_adel); end
    n_cmp++; if (out_pc[31:0] !== 32'h00400000 || out_instr[31:0] !== 32'h0) begin n_fail++; $display("FAIL halt_fields got=%h/%h exp=00400000/0", out_pc[31:0], out_instr[31:0]); end
    repeat (2) tick();
    n_cmp++; if (out_valid !== 2'b01 || ireq_valid !== 1'b0) begin n_fail++; $display("FAIL halt_stay got=%b/%b exp=01/0", out_valid, ireq_valid); end
    redir(32'hbfc00380);
    n_cmp++; if (out_valid !== 2'b00 || ireq_valid !== 1'b1 || ireq_addr !== 32'hbfc00380) begin n_fail++; $display("FAIL halt_resume got=%b/%b/%h exp=00/1/bfc00380", out_valid, ireq_valid, ireq_addr); end
  endtask

  task automatic test_back_to_back();
    resp(2'd2, {32'h22220001, 32'h22220000});
    n_cmp++; if (out_valid !== 2'b11 || out_irq !== 2'b00) begin n_fail++; $display("FAIL irq_off got=%b/%b exp=11/00", out_valid, out_irq); end
    irq_pending = 1'b1; deq_ready = 1'b1;
    resp(2'd2, {32'h33330001, 32'h33330000});
    irq_pending = 1'b0; deq_ready = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 2'b11 || out_pc !== {32'hbfc0038c, 32'hbfc00388}) begin n_fail++; $display("FAIL b2b_pc got=%b/%h exp=11/bfc0038cbfc00388", out_valid, out_pc); end
    n_cmp++; if (out_irq !== 2'b11) begin n_fail++; $display("FAIL irq_on got=%b exp=11", out_irq); end
    n_cmp++; if (ireq_addr !== 32'hbfc00390) begin n_fail++; $display("FAIL b2b_nextpc got=%h exp=bfc00390", ireq_addr); end
    pop_all();
    n_cmp++; if (out_valid !== 2'b00) begin n_fail++; $display("FAIL b2b_empty got=%b exp=00", out_valid); end
  endtask

  initial begin
    resetn = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; irq_pending = 1'b0;
    iresp_addr_ok = 1'b0; iresp_data_ok = 1'b0; iresp_count = '0; iresp_data = '0; deq_ready = 1'b0;
    test_reset();
    test_single();
    test_partial();
    test_stall();
    test_redirect_wait();
    test_halt();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
